// File: rtl/loop_fetch_if.sv
// Handshake bundle between the fetch/decode side and loop_fetch_sequencer.
// The master drives the decoded instruction; the slave returns the PC controls.
interface loop_fetch_if #(
    parameter int PC_WIDTH = 16
);
    logic [PC_WIDTH-1:0] pc;
    logic                is_open;
    logic                is_close;
    logic                cell_zero;
    logic                stall;
    logic                pc_src;
    logic                pc_write;
    logic [PC_WIDTH-1:0] pc_loaded;
    logic                exec_en;
    logic                error;
    logic                halted;

    modport master (
        output pc, is_open, is_close, cell_zero, stall,
        input  pc_src, pc_write, pc_loaded, exec_en, error, halted
    );

    modport slave (
        input  pc, is_open, is_close, cell_zero, stall,
        output pc_src, pc_write, pc_loaded, exec_en, error, halted
    );
endinterface

// File: rtl/loop_fetch_sequencer.sv
// '[' / ']' loop sequencer for the BeeF fetch unit: return-address stack plus forward-skip scanner.
// Define LOOP_FETCH_SEQ_DEBUG_EN to expose dbg_sp, dbg_skip_cnt and dbg_state.
module loop_fetch_sequencer #(
    parameter int PC_WIDTH    = 16,
    parameter int STACK_DEPTH = 16,
    parameter int SKIP_W      = 8
) (
    input  logic clk,
    input  logic reset,
    loop_fetch_if.slave bus
`ifdef LOOP_FETCH_SEQ_DEBUG_EN
    ,
    output logic [$clog2(STACK_DEPTH):0] dbg_sp,
    output logic [SKIP_W-1:0]            dbg_skip_cnt,
    output logic [1:0]                   dbg_state
`endif
);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;
    localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [SKIP_W-1:0] SKIP_MAX = '1;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SKIP = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [SP_W-1:0]     sp, sp_nxt;
    logic [SKIP_W-1:0]   skip_cnt, skip_nxt;
    logic [PC_WIDTH-1:0] stack [STACK_DEPTH];

    logic                push_en;
    logic                pc_write_c;
    logic                pc_src_c;
    logic                exec_en_c;
    logic [IDX_W-1:0]    top_idx;
    logic                stack_full;
    logic                stack_empty;

    // sp counts entries, so the top of stack lives one slot below it
    assign top_idx     = sp[IDX_W-1:0] - IDX_W'(1);
    assign stack_full  = (sp == SP_FULL);
    assign stack_empty = (sp == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            sp       <= '0;
            skip_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sp       <= sp_nxt;
            skip_cnt <= skip_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            stack[sp[IDX_W-1:0]] <= bus.pc;
        end
    end

    always_comb begin
        state_nxt  = state;
        sp_nxt     = sp;
        skip_nxt   = skip_cnt;
        push_en    = 1'b0;
        pc_write_c = 1'b0;
        pc_src_c   = 1'b0;
        exec_en_c  = 1'b0;

        case (state)
            RUN: begin
                if (!bus.stall) begin
                    if (bus.is_open && bus.is_close) begin
                        state_nxt = ERR;
                    end else if (bus.is_open) begin
                        if (bus.cell_zero) begin
                            state_nxt  = SKIP;
                            skip_nxt   = SKIP_W'(1);
                            pc_write_c = 1'b1;
                        end else if (stack_full) begin
                            state_nxt = ERR;
                        end else begin
                            push_en    = 1'b1;
                            sp_nxt     = sp + SP_W'(1);
                            pc_write_c = 1'b1;
                            exec_en_c  = 1'b1;
                        end
                    end else if (bus.is_close) begin
                        if (stack_empty) begin
                            state_nxt = ERR;
                        end else if (bus.cell_zero) begin
                            sp_nxt     = sp - SP_W'(1);
                            pc_write_c = 1'b1;
                            exec_en_c  = 1'b1;
                        end else begin
                            pc_src_c   = 1'b1;
                            pc_write_c = 1'b1;
                            exec_en_c  = 1'b1;
                        end
                    end else begin
                        pc_write_c = 1'b1;
                        exec_en_c  = 1'b1;
                    end
                end
            end

            // Skipping ignores stall: nothing commits, so the scan can always advance
            SKIP: begin
                pc_write_c = 1'b1;
                if (bus.is_open) begin
                    if (skip_cnt == SKIP_MAX) begin
                        state_nxt = ERR;
                    end else begin
                        skip_nxt = skip_cnt + SKIP_W'(1);
                    end
                end else if (bus.is_close) begin
                    if (skip_cnt == SKIP_W'(1)) begin
                        skip_nxt  = '0;
                        state_nxt = RUN;
                    end else begin
                        skip_nxt = skip_cnt - SKIP_W'(1);
                    end
                end
            end

            ERR: begin
                state_nxt = ERR;
            end

            default: begin
                state_nxt = ERR;
            end
        endcase

        if (reset) begin
            push_en    = 1'b0;
            pc_write_c = 1'b0;
            pc_src_c   = 1'b0;
            exec_en_c  = 1'b0;
        end
    end

    assign bus.pc_write  = pc_write_c;
    assign bus.pc_src    = pc_src_c;
    assign bus.exec_en   = exec_en_c;
    assign bus.pc_loaded = pc_src_c ? (stack[top_idx] + PC_WIDTH'(1)) : '0;
    assign bus.error     = (state == ERR) && !reset;
    assign bus.halted    = (state == ERR) && !reset;

`ifdef LOOP_FETCH_SEQ_DEBUG_EN
    assign dbg_sp       = sp;
    assign dbg_skip_cnt = skip_cnt;
    assign dbg_state    = state;
`endif
endmodule

// File: tb/tb_loop_fetch_sequencer.sv
// Scoreboard bench for loop_fetch_sequencer: directed loop scenarios plus random programs
// checked against a queue-based reference model of the loop rules.
module tb_loop_fetch_sequencer;
    localparam int PW  = 16;
    localparam int SD  = 16;
    localparam int SKW = 8;
    localparam int SKIP_LIMIT = (1 << SKW) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    loop_fetch_if #(.PC_WIDTH(PW)) bus ();

`ifdef LOOP_FETCH_SEQ_DEBUG_EN
    logic [$clog2(SD):0] dbg_sp;
    logic [SKW-1:0]      dbg_skip_cnt;
    logic [1:0]          dbg_state;
`endif

    loop_fetch_sequencer #(
        .PC_WIDTH(PW),
        .STACK_DEPTH(SD),
        .SKIP_W(SKW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
`ifdef LOOP_FETCH_SEQ_DEBUG_EN
        ,
        .dbg_sp(dbg_sp),
        .dbg_skip_cnt(dbg_skip_cnt),
        .dbg_state(dbg_state)
`endif
    );

    typedef struct {
        bit       pw;
        bit       src;
        bit [15:0] loaded;
        bit       ex;
        bit       err;
        bit       halt;
        bit       chk_flags;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: loop nesting as a queue of saved PCs, skipping as a depth count
    bit   m_err;
    int   m_depth;
    int   m_stack[$];
    int   m_pc;

    function automatic exp_t model_step(bit rst, bit op, bit cl, bit cz, bit st, int pcv);
        exp_t e;
        e = '{default: 0};
        e.chk_flags = 1'b1;
        if (rst) begin
            m_err = 0;
            m_depth = 0;
            m_stack.delete();
            e.chk_flags = 1'b0;
            m_pc = 0;
            return e;
        end
        if (m_err) begin
            e.err = 1;
            e.halt = 1;
        end else if (m_depth > 0) begin
            e.pw = 1;
            if (op) begin
                if (m_depth == SKIP_LIMIT) m_err = 1;
                else m_depth++;
            end else if (cl) begin
                m_depth--;
            end
        end else if (st) begin
            e.pw = 0;
        end else if (op && cl) begin
            m_err = 1;
        end else if (op) begin
            if (cz) begin
                m_depth = 1;
                e.pw = 1;
            end else if (m_stack.size() == SD) begin
                m_err = 1;
            end else begin
                m_stack.push_back(pcv);
                e.pw = 1;
                e.ex = 1;
            end
        end else if (cl) begin
            if (m_stack.size() == 0) begin
                m_err = 1;
            end else if (cz) begin
                void'(m_stack.pop_back());
                e.pw = 1;
                e.ex = 1;
            end else begin
                e.pw = 1;
                e.src = 1;
                e.loaded = 16'((m_stack[$] + 1) % 65536);
                e.ex = 1;
            end
        end else begin
            e.pw = 1;
            e.ex = 1;
        end
        if (e.pw) m_pc = e.src ? int'(e.loaded) : (pcv + 1) % 65536;
        else m_pc = pcv;
        return e;
    endfunction

    task automatic applyStimulus(input bit rst, input bit op, input bit cl,
                                 input bit cz, input bit st, input int pcv);
        exp_t e;
        reset         = rst;
        bus.is_open   = op;
        bus.is_close  = cl;
        bus.cell_zero = cz;
        bus.stall     = st;
        bus.pc        = 16'(pcv);
        e = model_step(rst, op, cl, cz, st, pcv);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("pc_write", int'(bus.pc_write), int'(e.pw));
            checkOutput("pc_src", int'(bus.pc_src), int'(e.src));
            checkOutput("pc_loaded", int'(bus.pc_loaded), int'(e.loaded));
            checkOutput("exec_en", int'(bus.exec_en), int'(e.ex));
            if (e.chk_flags) begin
                checkOutput("error", int'(bus.error), int'(e.err));
                checkOutput("halted", int'(bus.halted), int'(e.halt));
            end
        end
    end

    task automatic do_reset();
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0);
    endtask

    task automatic nop(input int pcv);
        applyStimulus(0, 0, 0, 0, 0, pcv);
    endtask

    // Random program executed with the model's PC acting as the fetch unit
    task automatic run_program(input string prog, input int cycles);
        byte ch;
        do_reset();
        for (int i = 0; i < cycles; i++) begin
            ch = (m_pc < prog.len()) ? prog[m_pc] : 8'h2B;
            applyStimulus(0, ch == 8'h5B, ch == 8'h5D, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 4) == 0, m_pc);
        end
    endtask

    function automatic string gen_program(bit balanced);
        string s;
        int depth;
        int len;
        int r;
        s = "";
        depth = 0;
        len = $urandom_range(6, 24);
        for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 5);
            if (r < 2) begin
                s = {s, "["};
                depth++;
            end else if (r < 4 && (depth > 0 || !balanced)) begin
                s = {s, "]"};
                depth--;
            end else begin
                s = {s, "+"};
            end
        end
        if (balanced) begin
            for (int i = 0; i < depth; i++) s = {s, "]"};
        end
        return s;
    endfunction

    initial begin
        reset = 1'b1;
        bus.is_open = 0;
        bus.is_close = 0;
        bus.cell_zero = 0;
        bus.stall = 0;
        bus.pc = '0;
        @(posedge clk);
        #1;

        do_reset();
        for (int p = 0; p < 4; p++) nop(p);

        // Loop re-entry then exit, then underflow proves the pop happened
        applyStimulus(0, 1, 0, 0, 0, 5);
        for (int p = 6; p < 9; p++) nop(p);
        applyStimulus(0, 0, 1, 0, 0, 9);
        applyStimulus(0, 0, 1, 1, 0, 9);
        applyStimulus(0, 0, 1, 0, 0, 10);
        for (int p = 0; p < 3; p++) nop(p);
        do_reset();

        // "[ [ ] + ]" skipped from pc 3, with a stall during the skip
        applyStimulus(0, 1, 0, 1, 0, 3);
        applyStimulus(0, 1, 0, 0, 1, 4);
        applyStimulus(0, 0, 1, 0, 0, 5);
        applyStimulus(0, 0, 0, 0, 1, 6);
        applyStimulus(0, 0, 1, 0, 0, 7);
        nop(8);
        nop(9);
        do_reset();

        // Stack overflow, sticky error, then reset empties the stack
        for (int p = 0; p <= SD; p++) applyStimulus(0, 1, 0, 0, 0, p);
        for (int p = 0; p < 3; p++) applyStimulus(0, 0, 0, 0, 0, 40 + p);
        do_reset();
        applyStimulus(0, 0, 1, 0, 0, 2);
        nop(3);
        do_reset();

        applyStimulus(0, 1, 1, 0, 0, 7);
        nop(8);
        do_reset();

        // Stalled '[' must push exactly once
        repeat (3) applyStimulus(0, 1, 0, 0, 1, 4);
        applyStimulus(0, 1, 0, 0, 0, 4);
        applyStimulus(0, 0, 1, 0, 0, 5);
        applyStimulus(0, 0, 1, 1, 0, 5);
        applyStimulus(0, 0, 1, 1, 0, 6);
        do_reset();

        // Jump target wraps past the top of the PC range
        applyStimulus(0, 1, 0, 0, 0, 16'hFFFF);
        applyStimulus(0, 0, 1, 0, 0, 0);
        do_reset();

        for (int n = 0; n < 24; n++) run_program(gen_program(n % 4 != 3), 120);

        repeat (4) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
